// File: rtl/sr_drv_pkg.sv
// Shared types and default timing for the sr_latch_driver block.
// Holds the FSM state enum and a window-decode helper.
package sr_drv_pkg;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_LEN = 1;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_CHECK_LAT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_HOLD,
        S_CLEAR,
        S_DONE
    } sr_drv_state_t;

    // States in which the latch enable window is open.
    function automatic logic in_window(sr_drv_state_t s);
        return s inside {S_SETUP, S_PULSE, S_GAP, S_HOLD};
    endfunction

    // States that count as a sequence in progress.
    function automatic logic is_busy(sr_drv_state_t s);
        return !(s inside {S_IDLE, S_DONE});
    endfunction

endpackage

// File: rtl/sr_latch_driver_cycle_timer.sv
// Loadable down-counter shared by every timed state of the driver.
// Ports: clk, rst (sync, high), load, value (W), expired.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Loaded with duration-1, so expired marks the last cycle of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives en windows and set pulses into a sticky latch, checks q.
// Ports: clk, rst, start, pulse_cnt, gap, q -> en, set, busy, done, err.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CHECK_LAT = DEF_CHECK_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] pulse_cnt,
    input  logic [CNT_W-1:0] gap,
    input  logic             q,
    output logic             en,
    output logic             set,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CHECK_LAT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    sr_drv_state_t    state, state_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [CNT_W-1:0] gap_r, gap_n;
    logic             nz_r, nz_n;
    logic             err_n;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;

    cycle_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_val),
        .expired(tmr_exp)
    );

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        gap_n    = gap_r;
        nz_n     = nz_r;
        err_n    = err;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    rem_n    = pulse_cnt;
                    gap_n    = (gap == '0) ? ONE : gap;
                    nz_n     = (pulse_cnt != '0);
                    err_n    = 1'b0;
                    state_n  = S_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (nz_r) begin
                        state_n = S_PULSE;
                        tmr_val = PULSE_LD;
                    end else begin
                        state_n = S_HOLD;
                        tmr_val = HOLD_LD;
                    end
                end
            end
            S_PULSE: begin
                if (tmr_exp) begin
                    rem_n    = rem - ONE;
                    tmr_load = 1'b1;
                    if (rem != ONE) begin
                        state_n = S_GAP;
                        tmr_val = gap_r - ONE;
                    end else begin
                        state_n = S_HOLD;
                        tmr_val = HOLD_LD;
                    end
                end
            end
            S_GAP: begin
                if (tmr_exp) begin
                    state_n  = S_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            S_HOLD: begin
                if (tmr_exp) begin
                    // q must reflect whether any pulse was issued.
                    if (q != nz_r) begin
                        err_n = 1'b1;
                    end
                    state_n  = S_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = CLEAR_LD;
                end
            end
            S_CLEAR: begin
                if (!q) begin
                    state_n = S_DONE;
                end else if (tmr_exp) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rem   <= '0;
            gap_r <= ONE;
            nz_r  <= 1'b0;
            err   <= 1'b0;
            en    <= 1'b0;
            set   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            gap_r <= gap_n;
            nz_r  <= nz_n;
            err   <= err_n;
            en    <= in_window(state_n);
            set   <= (state_n == S_PULSE);
            busy  <= is_busy(state_n);
            done  <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver with a behavioural latch model.
// Expected waveforms come from the sequence timing rules.
module tb_sr_latch_driver;

    localparam int CNT_W     = 8;
    localparam int SETUP_CYC = 2;
    localparam int PULSE_LEN = 1;
    localparam int HOLD_CYC  = 2;
    localparam int CHECK_LAT = 3;
    localparam int ML        = 512;

    typedef struct {
        int          len;
        logic [ML-1:0] enm;
        logic [ML-1:0] setm;
        logic        err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] gap;
    logic             q = 1'b0;
    logic             en, set, busy, done, err;

    int   tests = 0;
    int   fails = 0;
    int   mode  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sr_latch_driver #(
        .CNT_W    (CNT_W),
        .SETUP_CYC(SETUP_CYC),
        .PULSE_LEN(PULSE_LEN),
        .HOLD_CYC (HOLD_CYC),
        .CHECK_LAT(CHECK_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pulse_cnt(pulse_cnt),
        .gap      (gap),
        .q        (q),
        .en       (en),
        .set      (set),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Latch: 0 normal, 1 stuck at 1, 2 stuck at 0.
    always @(posedge clk) begin
        if (mode == 1)      q <= 1'b1;
        else if (mode == 2) q <= 1'b0;
        else if (!en)       q <= 1'b0;
        else if (set)       q <= 1'b1;
    end

    // Cycle 1 is the first cycle after the accepting edge.
    function automatic exp_t model(int cnt, int gp, int md);
        exp_t x;
        int g, e, s;
        g = (gp == 0) ? 1 : gp;
        e = SETUP_CYC + cnt * PULSE_LEN + HOLD_CYC;
        if (cnt > 0) e += (cnt - 1) * g;
        x.enm  = '0;
        x.setm = '0;
        for (int c = 1; c <= e; c++) x.enm[c] = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            s = SETUP_CYC + 1 + k * (PULSE_LEN + g);
            for (int j = 0; j < PULSE_LEN; j++) x.setm[s + j] = 1'b1;
        end
        case (md)
            1: begin
                x.len = e + CHECK_LAT + 1;
                x.err = 1'b1;
            end
            2: begin
                x.len = e + 2;
                x.err = (cnt != 0);
            end
            default: begin
                x.len = (cnt > 0) ? e + 3 : e + 2;
                x.err = 1'b0;
            end
        endcase
        return x;
    endfunction

    // Monitor: records en/set per cycle of a sequence, checks on done.
    logic [ML-1:0] ren, rset;
    int  off = 0;
    bit  active = 0;
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            active = 0;
        end else begin
            tests++;
            if (set && !en) begin
                fails++;
                $display("FAIL set_without_en: set=%0b en=%0b need set=0", set, en);
            end
            if (!active && busy) begin
                active = 1;
                off    = 0;
                ren    = '0;
                rset   = '0;
            end
            if (active && off < ML - 1) begin
                off++;
                ren[off]  = en;
                rset[off] = set;
            end
            if (done) begin
                if (!active || sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 need no done");
                end else begin
                    x = sb.pop_front();
                    tests += 4;
                    if (off != x.len) begin
                        fails++;
                        $display("FAIL done_cycle: got %0d need %0d", off, x.len);
                    end
                    if (ren != x.enm) begin
                        fails++;
                        $display("FAIL en_wave: got %h need %h", ren[127:0], x.enm[127:0]);
                    end
                    if (rset != x.setm) begin
                        fails++;
                        $display("FAIL set_wave: got %h need %h", rset[127:0], x.setm[127:0]);
                    end
                    if (err != x.err) begin
                        fails++;
                        $display("FAIL err_at_done: got %0b need %0b", err, x.err);
                    end
                end
                active = 0;
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h need %0h", name, got, want);
        end
    endtask

    task automatic issue(int cnt, int gp, int md);
        @(posedge clk);
        #1;
        mode = md;
        sb.push_back(model(cnt, gp, md));
        start     = 1'b1;
        pulse_cnt = CNT_W'(cnt);
        gap       = CNT_W'(gp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pulse_cnt = '0;
        gap       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outs", 32'({en, set, busy, done, err}), 32'd0);

        issue(2, 3, 0);
        wait_done();
        issue(0, 5, 0);
        wait_done();
        issue(3, 0, 0);
        wait_done();

        issue(2, 3, 1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        issue(1, 2, 0);
        check("err_clear_on_start", 32'(err), 32'd0);
        wait_done();

        issue(2, 3, 0);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        @(posedge clk);
        #1;
        start     = 1'b1;
        pulse_cnt = 8'd2;
        gap       = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_outs", 32'({en, set, busy, done, err}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst_stays_idle", 32'({busy, done}), 32'd0);
        end

        sb.push_back(model(1, 2, 0));
        sb.push_back(model(1, 2, 0));
        @(posedge clk);
        #1;
        start     = 1'b1;
        pulse_cnt = 8'd1;
        gap       = 8'd2;
        wait_done();
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        for (int i = 0; i < 25; i++) begin
            issue(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 2)));
            wait_done();
        end

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
